// File: rtl/clock_domain_gen.sv
// Multi-channel 50%-duty clock divider with run-time reconfiguration applied at ch0's fall point.
// Outputs are registered, so there are no combinational paths. cfg_ready is low while a captured setting waits to be applied.
module clock_domain_gen #(
  parameter int                        NUM_CH      = 4,
  parameter int                        CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0]   DEFAULT_DIV = {8'd3, 8'd3, 8'd0, 8'd0},
  parameter logic [NUM_CH-1:0]         DEFAULT_INV = 4'b1100
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_div,
  input  logic [NUM_CH-1:0]         cfg_inv,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         rise_tick
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                        state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  lim_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  sh_div_q;
  logic [NUM_CH-1:0]             tog_q, tog_d;
  logic [NUM_CH-1:0]             inv_q;
  logic [NUM_CH-1:0]             sh_inv_q;
  logic [NUM_CH-1:0]             clk_d;
  logic                          capture;
  logic                          apply;

  // Apply only at ch0's fall point so every channel restarts from a clean low phase.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    apply     = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          capture = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (tog_q[0] && (cnt_q[0] == lim_q[0])) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    tog_d = tog_q;
    clk_d = clk_out;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      tog_d[i] = tog_q[i];
      if (cnt_q[i] == lim_q[i]) begin
        cnt_d[i] = '0;
        tog_d[i] = ~tog_q[i];
      end
      clk_d[i] = tog_d[i] ^ inv_q[i];
      if (apply) begin
        cnt_d[i] = '0;
        tog_d[i] = 1'b0;
        clk_d[i] = sh_inv_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lim_q     <= DEFAULT_DIV;
      inv_q     <= DEFAULT_INV;
      cnt_q     <= '0;
      tog_q     <= '0;
      clk_out   <= DEFAULT_INV;
      rise_tick <= '0;
      sh_div_q  <= '0;
      sh_inv_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      clk_out   <= clk_d;
      rise_tick <= clk_d & ~clk_out;
      if (capture) begin
        sh_div_q <= cfg_div;
        sh_inv_q <= cfg_inv;
      end
      if (apply) begin
        lim_q <= sh_div_q;
        inv_q <= sh_inv_q;
      end
    end
  end

endmodule

// File: tb/tb_clock_domain_gen.sv
// Directed checks of clock_domain_gen defaults, reconfiguration, busy handling, reset and max divide,
// followed by a randomized run comparing tick counts and periods.
module tb_clock_domain_gen;

  logic        clock;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic [3:0]  cfg_inv;
  logic [3:0]  clk_out;
  logic [3:0]  rise_tick;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_clk  [8];
  logic [3:0] exp_rise [8];

  clock_domain_gen dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_inv   (cfg_inv),
    .clk_out   (clk_out),
    .rise_tick (rise_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_default_table(input string pfx);
    for (int e = 0; e < 8; e++) begin
      step();
      check_eq($sformatf("%s_clk_e%0d", pfx, e + 1), 32'(clk_out), 32'(exp_clk[e]));
      check_eq($sformatf("%s_rise_e%0d", pfx, e + 1), 32'(rise_tick), 32'(exp_rise[e]));
    end
  endtask

  int          t;
  int          cnt_pend;
  int          last_rise [4];
  int          ticks [4];
  int          rises [4];
  logic [7:0]  cur_lim [4];
  logic [7:0]  sh_lim [4];
  logic [3:0]  prev_clk;
  logic        prev_ready;
  logic        offered;

  initial begin
    exp_clk[0] = 4'b1111; exp_rise[0] = 4'b0011;
    exp_clk[1] = 4'b1100; exp_rise[1] = 4'b0000;
    exp_clk[2] = 4'b1111; exp_rise[2] = 4'b0011;
    exp_clk[3] = 4'b0000; exp_rise[3] = 4'b0000;
    exp_clk[4] = 4'b0011; exp_rise[4] = 4'b0011;
    exp_clk[5] = 4'b0000; exp_rise[5] = 4'b0000;
    exp_clk[6] = 4'b0011; exp_rise[6] = 4'b0011;
    exp_clk[7] = 4'b1100; exp_rise[7] = 4'b1100;

    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_inv   = '0;
    #1;
    repeat (3) step();
    check_eq("rst_clk", 32'(clk_out), 32'h c);
    check_eq("rst_rise", 32'(rise_tick), 32'h0);
    check_eq("rst_rdy", 32'(cfg_ready), 32'h1);
    reset = 1'b0;
    run_default_table("dflt");

    // Reconfigure: ch0 -> lim 2, all non-inverted; apply lands on the next edge.
    cfg_valid = 1'b1;
    cfg_div   = {8'd3, 8'd3, 8'd0, 8'd2};
    cfg_inv   = 4'b0000;
    step();
    check_eq("cap_rdy", 32'(cfg_ready), 32'h0);
    check_eq("cap_clk", 32'(clk_out), 32'h f);
    cfg_valid = 1'b0;
    step();
    check_eq("apply_clk", 32'(clk_out), 32'h0);
    check_eq("apply_rdy", 32'(cfg_ready), 32'h1);
    check_eq("apply_rise", 32'(rise_tick), 32'h0);
    repeat (3) step();
    check_eq("a3_clk", 32'(clk_out), 32'h3);
    check_eq("a3_rise", 32'(rise_tick), 32'h3);
    step();
    check_eq("a4_clk", 32'(clk_out), 32'h d);
    check_eq("a4_rise", 32'(rise_tick), 32'h c);
    repeat (20) step();
    check_eq("a24_clk", 32'(clk_out), 32'h0);
    repeat (3) step();
    check_eq("a27_clk", 32'(clk_out), 32'h3);
    check_eq("a27_rise", 32'(rise_tick), 32'h3);
    step();
    check_eq("a28_clk", 32'(clk_out), 32'h d);
    check_eq("a28_rise", 32'(rise_tick), 32'h c);

    // Busy: valid stays high with a different setting while pending.
    cfg_valid = 1'b1;
    cfg_div   = {8'd1, 8'd1, 8'd1, 8'd1};
    cfg_inv   = 4'b0000;
    step();
    check_eq("busy_cap_rdy", 32'(cfg_ready), 32'h0);
    cfg_div   = {8'd0, 8'd0, 8'd0, 8'd0};
    cfg_inv   = 4'b1111;
    step();
    check_eq("busy_apply_rdy", 32'(cfg_ready), 32'h1);
    check_eq("busy_apply_clk", 32'(clk_out), 32'h0);
    step();
    check_eq("busy_second_rdy", 32'(cfg_ready), 32'h0);
    check_eq("busy_second_clk", 32'(clk_out), 32'h0);
    cfg_valid = 1'b0;
    step();
    check_eq("busy_b2_clk", 32'(clk_out), 32'h f);
    check_eq("busy_b2_rise", 32'(rise_tick), 32'h f);
    step();
    check_eq("busy_b3_rdy", 32'(cfg_ready), 32'h0);
    step();
    check_eq("busy_c_rdy", 32'(cfg_ready), 32'h1);
    check_eq("busy_c_clk", 32'(clk_out), 32'h f);
    check_eq("busy_c_rise", 32'(rise_tick), 32'h0);
    step();
    check_eq("busy_c1_clk", 32'(clk_out), 32'h0);
    step();
    check_eq("busy_c2_clk", 32'(clk_out), 32'h f);
    check_eq("busy_c2_rise", 32'(rise_tick), 32'h f);

    // Reset while a setting is pending drops it.
    cfg_valid = 1'b1;
    cfg_div   = {8'd2, 8'd2, 8'd2, 8'd5};
    cfg_inv   = 4'b0000;
    step();
    check_eq("midpend_rdy", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    reset     = 1'b1;
    step();
    check_eq("midpend_rst_clk", 32'(clk_out), 32'h c);
    check_eq("midpend_rst_rdy", 32'(cfg_ready), 32'h1);
    check_eq("midpend_rst_rise", 32'(rise_tick), 32'h0);
    reset = 1'b0;
    run_default_table("post_rst");

    // Max divide on ch0: half period 256.
    cfg_valid = 1'b1;
    cfg_div   = {8'd0, 8'd0, 8'd0, 8'd255};
    cfg_inv   = 4'b0000;
    step();
    cfg_valid = 1'b0;
    step();
    check_eq("max_apply_rdy", 32'(cfg_ready), 32'h1);
    check_eq("max_apply_clk0", 32'(clk_out[0]), 32'h0);
    repeat (255) step();
    check_eq("max_low_end", 32'(clk_out[0]), 32'h0);
    step();
    check_eq("max_rise", 32'(clk_out[0]), 32'h1);
    check_eq("max_rise_tick", 32'(rise_tick[0]), 32'h1);
    repeat (255) step();
    check_eq("max_high_end", 32'(clk_out[0]), 32'h1);
    step();
    check_eq("max_fall", 32'(clk_out[0]), 32'h0);

    cfg_valid = 1'b1;
    cfg_div   = {8'd3, 8'd3, 8'd0, 8'd0};
    cfg_inv   = 4'b1100;
    step();
    cfg_valid = 1'b0;
    cnt_pend  = 0;
    while (!cfg_ready && cnt_pend < 600) begin
      cnt_pend++;
      step();
    end
    check_eq("max_pend_len", 32'(cnt_pend), 32'd511);

    // Random reconfigurations: tick count and period per epoch.
    cur_lim[0] = 8'd0; cur_lim[1] = 8'd0; cur_lim[2] = 8'd3; cur_lim[3] = 8'd3;
    for (int i = 0; i < 4; i++) begin
      last_rise[i] = -1;
      ticks[i]     = 0;
      rises[i]     = 0;
      sh_lim[i]    = cur_lim[i];
    end
    prev_clk   = clk_out;
    prev_ready = cfg_ready;
    for (t = 1; t <= 2000; t++) begin
      offered = 1'b0;
      if (prev_ready && $urandom_range(0, 9) == 0) begin
        cfg_valid = 1'b1;
        for (int i = 0; i < 4; i++)
          cfg_div[i*8 +: 8] = (i == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 15));
        cfg_inv = 4'($urandom_range(0, 15));
        offered = 1'b1;
      end
      step();
      cfg_valid = 1'b0;
      if (offered)
        for (int i = 0; i < 4; i++) sh_lim[i] = cfg_div[i*8 +: 8];
      if (!prev_ready && cfg_ready) begin
        for (int i = 0; i < 4; i++) begin
          cur_lim[i]   = sh_lim[i];
          last_rise[i] = -1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (rise_tick[i]) ticks[i]++;
        if (clk_out[i] && !prev_clk[i]) begin
          rises[i]++;
          if (last_rise[i] >= 0)
            check_eq($sformatf("rand_period_ch%0d", i), 32'(t - last_rise[i]),
                     32'(2 * (int'(cur_lim[i]) + 1)));
          last_rise[i] = t;
        end
      end
      prev_clk   = clk_out;
      prev_ready = cfg_ready;
    end
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("rand_ticks_ch%0d", i), 32'(ticks[i]), 32'(rises[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
